// File: rtl/wam_btn.sv
// Button and switch conditioning for the whack-a-mole top level.
// Latency: 2-cycle synchroniser, then DB_TICKS debounce ticks; outputs are registered.
// Backpressure: none. Pulses are one cycle wide and are never held or queued.
//
// Ports:
//   clk      system clock, all state on posedge
//   clr      asynchronous active-high reset
//   lft_raw  raw left button (async, active high)
//   rgt_raw  raw right button (async, active high)
//   pse_raw  raw pause button (async, active high)
//   sw_raw   raw mole switches (async)
//   lft_p    one-cycle pulse per accepted left press or auto-repeat
//   rgt_p    one-cycle pulse per accepted right press or auto-repeat
//   pse_flg  pause level, toggles once per accepted pause press
//   sw_db    debounced switch levels

// Debounce FSM for one button, with optional auto-repeat.
// REP=1: q is a one-cycle pulse on accept and on every repeat.
// REP=0: q toggles on accept, and there is no auto-repeat.
module wam_btn_deb #(
    parameter int DB_TICKS = 20,
    parameter int REP_DLY  = 500,
    parameter int REP_PER  = 100,
    parameter int CW       = 10,
    parameter bit REP      = 1'b1
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic lvl,
    output logic q
);
    typedef enum logic [2:0] {IDLE, DEB_ON, HELD, REPEAT, DEB_OFF} st_t;

    localparam logic [CW-1:0] DB_C  = CW'(DB_TICKS);
    localparam logic [CW-1:0] DLY_C = CW'(REP_DLY);
    localparam logic [CW-1:0] PER_C = CW'(REP_PER);

    st_t           st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st  <= IDLE;
            cnt <= '0;
            q   <= 1'b0;
        end else begin
            // Pulse mode: q is high only in the cycle after a firing tick.
            if (REP) q <= 1'b0;
            if (tick) begin
                case (st)
                    IDLE: begin
                        // cnt is 0 here, so cnt_inc counts this first agreeing sample.
                        if (lvl) begin
                            if (cnt_inc == DB_C) begin
                                st  <= HELD;
                                cnt <= '0;
                                q   <= REP ? 1'b1 : ~q;
                            end else begin
                                st  <= DEB_ON;
                                cnt <= CW'(1);
                            end
                        end
                    end
                    DEB_ON: begin
                        if (!lvl) begin
                            st  <= IDLE;
                            cnt <= '0;
                        end else if (cnt_inc == DB_C) begin
                            st  <= HELD;
                            cnt <= '0;
                            q   <= REP ? 1'b1 : ~q;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HELD, REPEAT: begin
                        if (!lvl) begin
                            if (DB_C == CW'(1)) begin
                                st  <= IDLE;
                                cnt <= '0;
                            end else begin
                                st  <= DEB_OFF;
                                cnt <= CW'(1);
                            end
                        end else if (REP) begin
                            if (cnt_inc == ((st == HELD) ? DLY_C : PER_C)) begin
                                st  <= REPEAT;
                                cnt <= '0;
                                q   <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    DEB_OFF: begin
                        // A bounce back to 1 restarts the repeat delay without a pulse.
                        if (lvl) begin
                            st  <= HELD;
                            cnt <= '0;
                        end else if (cnt_inc == DB_C) begin
                            st  <= IDLE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        st  <= IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule

module wam_btn #(
    parameter int TICK_DIV = 100000,
    parameter int DB_TICKS = 20,
    parameter int REP_DLY  = 500,
    parameter int REP_PER  = 100
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       lft_raw,
    input  logic       rgt_raw,
    input  logic       pse_raw,
    input  logic [7:0] sw_raw,
    output logic       lft_p,
    output logic       rgt_p,
    output logic       pse_flg,
    output logic [7:0] sw_db
);
    localparam int MAX1 = (DB_TICKS > REP_DLY) ? DB_TICKS : REP_DLY;
    localparam int MAXT = (MAX1 > REP_PER) ? MAX1 : REP_PER;
    localparam int CW   = $clog2(MAXT) + 1;
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] DB_C = CW'(DB_TICKS);

    // Two-flop synchroniser; bit order {sw, pse, rgt, lft}.
    logic [10:0] s1;
    logic [10:0] s2;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {sw_raw, pse_raw, rgt_raw, lft_raw};
            s2 <= s1;
        end
    end

    logic       lft_s;
    logic       rgt_s;
    logic       pse_s;
    logic [7:0] sw_s;

    assign lft_s = s2[0];
    assign rgt_s = s2[1];
    assign pse_s = s2[2];
    assign sw_s  = s2[10:3];

    // Sample tick: first tick is TICK_DIV cycles after reset release.
    logic [TW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    wam_btn_deb #(
        .DB_TICKS(DB_TICKS), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .CW(CW), .REP(1'b1)
    ) u_lft (
        .clk(clk), .clr(clr), .tick(tick), .lvl(lft_s), .q(lft_p)
    );

    wam_btn_deb #(
        .DB_TICKS(DB_TICKS), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .CW(CW), .REP(1'b1)
    ) u_rgt (
        .clk(clk), .clr(clr), .tick(tick), .lvl(rgt_s), .q(rgt_p)
    );

    wam_btn_deb #(
        .DB_TICKS(DB_TICKS), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .CW(CW), .REP(1'b0)
    ) u_pse (
        .clk(clk), .clr(clr), .tick(tick), .lvl(pse_s), .q(pse_flg)
    );

    // Switches: per-bit disagreement counter, cleared whenever a sample
    // matches the current debounced level.
    logic [CW-1:0] swc [8];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) swc[i] <= '0;
            sw_db <= '0;
        end else if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (sw_s[i] == sw_db[i]) begin
                    swc[i] <= '0;
                end else if ((swc[i] + CW'(1)) == DB_C) begin
                    sw_db[i] <= sw_s[i];
                    swc[i]   <= '0;
                end else begin
                    swc[i] <= swc[i] + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_wam_btn.sv
// Self-checking bench for wam_btn with small tick/debounce parameters.
// Expected pulse cycles and level changes are derived from stimulus timing.
// Inputs change 2 time units after each negedge; outputs are sampled at negedge.
module tb_wam_btn;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       lft_raw = 1'b0;
    logic       rgt_raw = 1'b0;
    logic       pse_raw = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic       lft_p;
    logic       rgt_p;
    logic       pse_flg;
    logic [7:0] sw_db;

    wam_btn #(.TICK_DIV(TD), .DB_TICKS(DB), .REP_DLY(RD), .REP_PER(RP)) dut (
        .clk(clk), .clr(clr),
        .lft_raw(lft_raw), .rgt_raw(rgt_raw), .pse_raw(pse_raw), .sw_raw(sw_raw),
        .lft_p(lft_p), .rgt_p(rgt_p), .pse_flg(pse_flg), .sw_db(sw_db)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    int  gcyc = 0;     // number of posedges so far
    int  base = 0;     // gcyc at the last clr release
    int  n_chk = 0;
    int  n_bad = 0;
    int  lft_q[$];
    int  rgt_q[$];
    ev_t pse_q[$];
    ev_t sw_q[$];
    int  exp_pse = 0;
    int  exp_sw = 0;
    bit  e_l;
    bit  e_r;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, gcyc, got, exp);
        end
    endtask

    // First tick edge that sees a raw level driven during cycle c.
    function automatic int first_tick(input int c);
        int g;
        g = c + 3;
        while (((g - base) % TD) != 0) g++;
        return g;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_until(input int g);
        while (gcyc < g) step(1);
    endtask

    // Output monitor / scoreboard pop side.
    always @(negedge clk) begin
        if (clr) begin
            chk("rst_lft_p", lft_p, 0);
            chk("rst_rgt_p", rgt_p, 0);
            chk("rst_pse_flg", pse_flg, 0);
            chk("rst_sw_db", sw_db, 0);
        end else begin
            e_l = (lft_q.size() > 0) && (lft_q[0] == gcyc);
            if (e_l) void'(lft_q.pop_front());
            if (e_l || lft_p) chk("lft_p", lft_p, e_l);
            e_r = (rgt_q.size() > 0) && (rgt_q[0] == gcyc);
            if (e_r) void'(rgt_q.pop_front());
            if (e_r || rgt_p) chk("rgt_p", rgt_p, e_r);
            if (pse_q.size() > 0 && pse_q[0].cyc == gcyc) begin
                exp_pse = pse_q[0].val;
                void'(pse_q.pop_front());
            end
            chk("pse_flg", pse_flg, exp_pse);
            if (sw_q.size() > 0 && sw_q[0].cyc == gcyc) begin
                exp_sw = sw_q[0].val;
                void'(sw_q.pop_front());
            end
            chk("sw_db", sw_db, exp_sw);
        end
    end

    initial begin
        int c;
        int p;

        // Reset with random raw activity.
        for (int i = 0; i < 6; i++) begin
            step(1);
            lft_raw = 1'($urandom_range(0, 1));
            rgt_raw = 1'($urandom_range(0, 1));
            pse_raw = 1'($urandom_range(0, 1));
            sw_raw  = 8'($urandom_range(0, 255));
        end
        step(1);
        lft_raw = 1'b0;
        rgt_raw = 1'b0;
        pse_raw = 1'b0;
        sw_raw  = 8'h00;
        clr     = 1'b0;
        base    = gcyc;

        // Clean left press, 10 ticks, then release.
        step(5);
        c = gcyc;
        lft_raw = 1'b1;
        lft_q.push_back(first_tick(c) + TD * (DB - 1));
        step(10 * TD);
        lft_raw = 1'b0;
        step(40);

        // Bouncing left button: toggles every 3 cycles.
        for (int i = 0; i < 14; i++) begin
            lft_raw = ~lft_raw;
            step(3);
        end
        lft_raw = 1'b0;
        step(40);

        // Right held: accept, then repeats at +8, +12, +16, +20 ticks.
        c = gcyc;
        rgt_raw = 1'b1;
        p = first_tick(c) + TD * (DB - 1);
        rgt_q.push_back(p);
        rgt_q.push_back(p + TD * RD);
        rgt_q.push_back(p + TD * (RD + RP));
        rgt_q.push_back(p + TD * (RD + 2 * RP));
        rgt_q.push_back(p + TD * (RD + 3 * RP));
        wait_until(p + TD * (RD + 3 * RP) + 4);
        rgt_raw = 1'b0;
        step(40);

        // Two clean pause presses, then a one-tick glitch.
        for (int k = 0; k < 2; k++) begin
            c = gcyc;
            pse_raw = 1'b1;
            pse_q.push_back('{first_tick(c) + TD * (DB - 1), (k == 0) ? 1 : 0});
            step(8 * TD);
            pse_raw = 1'b0;
            step(8 * TD);
        end
        pse_raw = 1'b1;
        step(TD);
        pse_raw = 1'b0;
        step(8 * TD);

        // Switches: settle to A5, one-tick glitch, then move to 3C.
        c = gcyc;
        sw_raw = 8'hA5;
        sw_q.push_back('{first_tick(c) + TD * (DB - 1), 32'hA5});
        step(5 * TD);
        sw_raw = 8'h00;
        step(TD);
        sw_raw = 8'hA5;
        step(5 * TD);
        c = gcyc;
        sw_raw = 8'h3C;
        sw_q.push_back('{first_tick(c) + TD * (DB - 1), 32'h3C});
        step(6 * TD);

        // Left held into REPEAT, clr asserted during a repeat pulse.
        c = gcyc;
        lft_raw = 1'b1;
        p = first_tick(c) + TD * (DB - 1);
        lft_q.push_back(p);
        lft_q.push_back(p + TD * RD);
        lft_q.push_back(p + TD * (RD + RP));
        wait_until(p + TD * (RD + RP));
        clr = 1'b1;
        lft_q.delete();
        rgt_q.delete();
        pse_q.delete();
        sw_q.delete();
        exp_pse = 0;
        exp_sw  = 0;
        #1;
        chk("clr_lft_p", lft_p, 0);
        chk("clr_sw_db", sw_db, 0);
        chk("clr_pse_flg", pse_flg, 0);
        step(3);
        clr  = 1'b0;
        base = gcyc;
        // Still held: treated as a fresh press needing full debounce.
        lft_q.push_back(first_tick(base) + TD * (DB - 1));
        sw_q.push_back('{first_tick(base) + TD * (DB - 1), 32'h3C});
        wait_until(base + 5 * TD);
        lft_raw = 1'b0;
        step(40);

        chk("lft_q_left", lft_q.size(), 0);
        chk("rgt_q_left", rgt_q.size(), 0);
        chk("pse_q_left", pse_q.size(), 0);
        chk("sw_q_left", sw_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
